// File: rtl/key_sel_pkg.sv
// Shared definitions for the debounced key-to-mux-select front end:
// FSM state encodings and default debounce/long-press windows.
package key_sel_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } state_e;

    localparam logic [19:0] CNT_MAX_DEF  = 20'd999_999;
    localparam logic [25:0] LONG_MAX_DEF = 26'd49_999_999;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for the raw, asynchronous key input.
// Both stages reset to 1 (the key's idle level).
module key_sync (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of d into the sys_clk domain
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/key_sel_ctrl.sv
// Debounced push-button to 2:1 mux select: sel toggles once per confirmed press.
// Optional long-press handling is enabled by defining KEY_LONG_EN.
module key_sel_ctrl
    import key_sel_pkg::*;
#(
    parameter logic [19:0] CNT_MAX  = CNT_MAX_DEF,
    parameter logic [25:0] LONG_MAX = LONG_MAX_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic sel,
    output logic key_flag,
    output logic long_flag
);

    localparam int CNT_W = (CNT_MAX == 20'd0) ? 1 : $clog2(int'(CNT_MAX) + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX[CNT_W-1:0];

    logic             key_sync_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             key_flag_q, key_flag_d;
`ifdef KEY_LONG_EN
    logic [25:0]      lcnt_q, lcnt_d;
    logic             long_flag_q, long_flag_d;
`endif

    key_sync u_sync (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .d       (key_in),
        .q       (key_sync_s)
    );

    // Next-state, debounce counter and output decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        key_flag_d = 1'b0;
`ifdef KEY_LONG_EN
        lcnt_d      = lcnt_q;
        long_flag_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = {CNT_W{1'b0}};
                if (!key_sync_s) begin
                    state_d = PRESS_DB;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESS_DB: begin
                if (key_sync_s) begin
                    state_d = IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = PRESSED;
                    cnt_d      = {CNT_W{1'b0}};
                    key_flag_d = 1'b1;
                    sel_d      = ~sel_q;
`ifdef KEY_LONG_EN
                    lcnt_d     = 26'd0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                cnt_d = {CNT_W{1'b0}};
                if (key_sync_s) begin
                    state_d = RELEASE_DB;
                end else begin
                    state_d = PRESSED;
                end
`ifdef KEY_LONG_EN
                // Counter stops one past the threshold so a held key fires only once
                if (lcnt_q == LONG_MAX) begin
                    long_flag_d = 1'b1;
                    sel_d       = 1'b0;
                end else begin
                    long_flag_d = 1'b0;
                end
                if (lcnt_q <= LONG_MAX) begin
                    lcnt_d = lcnt_q + 26'd1;
                end else begin
                    lcnt_d = lcnt_q;
                end
`endif
            end
            RELEASE_DB: begin
                if (!key_sync_s) begin
                    state_d = PRESSED;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state, debounce counter and registered outputs
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            sel_q      <= 1'b0;
            key_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            key_flag_q <= key_flag_d;
        end
    end

`ifdef KEY_LONG_EN
    // Long-press counter and its one-cycle flag
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            lcnt_q      <= 26'd0;
            long_flag_q <= 1'b0;
        end else begin
            lcnt_q      <= lcnt_d;
            long_flag_q <= long_flag_d;
        end
    end

    assign long_flag = long_flag_q;
`else
    // LONG_MAX stays on the interface so both builds share one parameter list
    localparam logic LONG_TIE = (LONG_MAX == 26'd0) & 1'b0;
    assign long_flag = LONG_TIE;
`endif

    assign sel      = sel_q;
    assign key_flag = key_flag_q;

endmodule

// File: tb/tb_key_sel_ctrl.sv
// Bench for key_sel_ctrl: directed scenarios plus random key activity, each cycle
// compared against a streak-counting reference model. Honours KEY_LONG_EN.
module tb_key_sel_ctrl;

    localparam logic [19:0] CNT_MAX  = 20'd4;
    localparam logic [25:0] LONG_MAX = 26'd19;
    localparam int CONFIRM  = int'(CNT_MAX) + 2;
    localparam int LONG_LIM = int'(LONG_MAX);

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic key_in  = 1'b1;
    logic sel, key_flag, long_flag;

    key_sel_ctrl #(.CNT_MAX(CNT_MAX), .LONG_MAX(LONG_MAX)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .key_in    (key_in),
        .sel       (sel),
        .key_flag  (key_flag),
        .long_flag (long_flag)
    );

    always #10 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model: key seen through a 2-stage delay, confirmation after a streak
    logic m_s1, m_s2, m_pressed, m_sel, m_flag, m_lflag;
    int   m_run, m_lc;

    int edge_n, n_flags, flag_edge, n_lflags, lflag_edge;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic k, input logic r);
        logic s;
        if (r) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_pressed = 1'b0; m_run = 0;
            m_sel = 1'b0; m_flag = 1'b0; m_lflag = 1'b0; m_lc = 0;
        end else begin
            s       = m_s2;
            m_flag  = 1'b0;
            m_lflag = 1'b0;
`ifdef KEY_LONG_EN
            if (m_pressed && m_run == 0) begin
                if (m_lc == LONG_LIM) begin
                    m_lflag = 1'b1;
                    m_sel   = 1'b0;
                end
                if (m_lc <= LONG_LIM) m_lc++;
            end
`endif
            if (!m_pressed) begin
                m_run = (s == 1'b0) ? m_run + 1 : 0;
                if (m_run == CONFIRM) begin
                    m_pressed = 1'b1; m_run = 0; m_flag = 1'b1; m_sel = ~m_sel; m_lc = 0;
                end
            end else begin
                m_run = (s == 1'b1) ? m_run + 1 : 0;
                if (m_run == CONFIRM) begin
                    m_pressed = 1'b0; m_run = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = k;
        end
    endtask

    task automatic cyc(input logic k, input logic r);
        key_in  = k;
        sys_rst = r;
        @(posedge sys_clk);
        model_edge(k, r);
        edge_n++;
        @(negedge sys_clk);
        chk("sel", sel, m_sel);
        chk("key_flag", key_flag, m_flag);
        chk("long_flag", long_flag, m_lflag);
        if (key_flag === 1'b1) begin n_flags++; flag_edge = edge_n; end
        if (long_flag === 1'b1) begin n_lflags++; lflag_edge = edge_n; end
    endtask

    task automatic clr_stats();
        edge_n = 0; n_flags = 0; flag_edge = -1; n_lflags = 0; lflag_edge = -1;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        clr_stats();
    endtask

    initial begin
        logic lvl, r;
        int   len;
        model_edge(1'b1, 1'b1);
        clr_stats();

        // 1: reset held 3 cycles with key idle
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
        chk("t1_sel_in_rst", sel, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        chk("t1_sel_after", sel, 1'b0);
        chk("t1_flag_after", key_flag, 1'b0);
        chk("t1_long_after", long_flag, 1'b0);

        // 2: clean press then release
        clr_stats();
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0);
        chk_n("t2_nflags", n_flags, 1);
        chk_n("t2_flag_edge", flag_edge, 8);
        chk("t2_sel", sel, 1'b1);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0);
        chk_n("t2_nflags_rel", n_flags, 1);
        chk("t2_sel_rel", sel, 1'b1);

        // 3: bouncing key never confirms
        do_reset();
        for (int i = 0; i < 12; i++) cyc(((i / 2) % 2) == 0 ? 1'b0 : 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0);
        chk_n("t3_nflags", n_flags, 0);
        chk("t3_sel", sel, 1'b0);

        // 4: two clean presses
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
            for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0);
            chk("t4_sel", sel, (p == 0) ? 1'b1 : 1'b0);
        end
        chk_n("t4_nflags", n_flags, 2);

        // 5: reset mid-press aborts it, held key confirms afresh
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        chk_n("t5_nflags_abort", n_flags, 0);
        chk("t5_sel_abort", sel, 1'b0);
        clr_stats();
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0);
        chk_n("t5_nflags", n_flags, 1);
        chk_n("t5_flag_edge", flag_edge, 8);
        chk("t5_sel", sel, 1'b1);

        // 6: long hold
        do_reset();
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0);
        chk_n("t6_flag_edge", flag_edge, 8);
        chk_n("t6_nflags", n_flags, 1);
`ifdef KEY_LONG_EN
        chk_n("t6_nlong", n_lflags, 1);
        chk_n("t6_long_edge", lflag_edge, 28);
        chk("t6_sel", sel, 1'b0);
`else
        chk_n("t6_nlong", n_lflags, 0);
        chk("t6_sel", sel, 1'b1);
`endif
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0);

        // random key activity with occasional reset pulses
        do_reset();
        for (int b = 0; b < 250; b++) begin
            lvl = 1'($urandom_range(0, 1));
            len = (($urandom_range(0, 3)) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 9);
            for (int i = 0; i < len; i++) begin
                r = ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0;
                cyc(lvl, r);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
